sopc_compteur_boutons: RTL and testbench

//  Avalon-MM slave input port: samples external push-buttons, synchronizes and debounces them,

---
 rtl/sopc_compteur_boutons.sv | 148 ++++++++++++++
 tb/tb_sopc_compteur_boutons.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sopc_compteur_boutons.sv
// sopc_compteur_boutons
// Avalon-MM slave that samples push-buttons through a 2-FF synchronizer,
// debounces each bit with its own stability counter, latches the selected
// debounced edges into a sticky RW1C capture register and raises a level
// interrupt while any enabled capture bit is pending. Zero wait states.
module sopc_compteur_boutons #(
  parameter int                 WIDTH      = 4,
  parameter int                 DEBOUNCE   = 50000,
  parameter int                 EDGE_TYPE  = 1,
  parameter logic [WIDTH-1:0]   IDLE_LEVEL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Counter must be able to hold DEBOUNCE-1; at least one bit wide.
  localparam int             CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] sync_a_q, sync_a_d;
  logic [WIDTH-1:0] sync_b_q, sync_b_d;
  logic [WIDTH-1:0] deb_q,    deb_d;
  logic [WIDTH-1:0] prev_q,   prev_d;
  logic [WIDTH-1:0] mask_q,   mask_d;
  logic [WIDTH-1:0] cap_q,    cap_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  logic             wr_en_s;
  logic [WIDTH-1:0] wr_data_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] cap_clr_s;
  logic             wr_unused_s;

  assign wr_en_s     = chipselect & ~write_n;
  assign wr_data_s   = writedata[WIDTH-1:0];
  // Upper write-data bits have no register behind them.
  assign wr_unused_s = ^writedata[31:WIDTH];

  // Two-stage synchronizer for the asynchronous button pins.
  always_comb begin
    sync_a_d = in_port;
    sync_b_d = sync_a_q;
  end

  // Per-bit debounce: the output follows the synchronized pin only after it
  // has disagreed for DEBOUNCE consecutive cycles; any return resets the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_b_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync_b_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Edge detection on the debounced state, filtered by the selected polarity.
  always_comb begin
    prev_d = deb_q;
    rise_s = ~prev_q & deb_q;
    fall_s = prev_q & ~deb_q;
    case (EDGE_TYPE)
      0:       edge_s = rise_s;
      1:       edge_s = fall_s;
      default: edge_s = rise_s | fall_s;
    endcase
  end

  // Register writes: IRQMASK is plain RW; EDGECAP is sticky with write-1-to-clear,
  // and a new edge in the same cycle as its clear keeps the bit set.
  always_comb begin
    mask_d    = mask_q;
    cap_clr_s = '0;
    if (wr_en_s && (address == ADDR_IRQMASK)) begin
      mask_d = wr_data_s;
    end else begin
      mask_d = mask_q;
    end
    if (wr_en_s && (address == ADDR_EDGECAP)) begin
      cap_clr_s = wr_data_s;
    end else begin
      cap_clr_s = '0;
    end
    cap_d = edge_s | (cap_q & ~cap_clr_s);
  end

  // State registers; reset returns the inputs to their idle level so that no
  // spurious edge is seen when reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a_q <= IDLE_LEVEL;
      sync_b_q <= IDLE_LEVEL;
      deb_q    <= IDLE_LEVEL;
      prev_q   <= IDLE_LEVEL;
      mask_q   <= '0;
      cap_q    <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_a_q <= sync_a_d;
      sync_b_q <= sync_b_d;
      deb_q    <= deb_d;
      prev_q   <= prev_d;
      mask_q   <= mask_d;
      cap_q    <= cap_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Zero-latency read mux; unused upper bits read as zero.
  always_comb begin
    case (address)
      ADDR_DATA:    readdata = {{(32-WIDTH){1'b0}}, deb_q};
      ADDR_RSVD:    readdata = 32'h0000_0000;
      ADDR_IRQMASK: readdata = {{(32-WIDTH){1'b0}}, mask_q};
      ADDR_EDGECAP: readdata = {{(32-WIDTH){1'b0}}, cap_q};
      default:      readdata = 32'h0000_0000;
    endcase
  end

  // Level interrupt straight from the registers.
  assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_sopc_compteur_boutons.sv
// Testbench for sopc_compteur_boutons: directed scenarios followed by random
// button/bus traffic, compared every cycle against a window-based model.
// Two instances share all inputs: one captures falling edges, one both edges.
module tb_sopc_compteur_boutons;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd_f, rd_b;
  logic        irq_f, irq_b;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [3:0] m_s1, m_s2, m_deb, m_prev, m_mask, m_cap_f, m_cap_b;
  logic [3:0] m_win[$];

  always #5 clk = ~clk;

  sopc_compteur_boutons #(.WIDTH(4), .DEBOUNCE(D), .EDGE_TYPE(1), .IDLE_LEVEL(4'hF)) u_dut_f (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_f), .irq(irq_f));

  sopc_compteur_boutons #(.WIDTH(4), .DEBOUNCE(D), .EDGE_TYPE(2), .IDLE_LEVEL(4'hF)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_b), .irq(irq_b));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  // The debounced bit flips once the last D synchronized samples all differ from it.
  task automatic model_step();
    logic [3:0] fall, rise, clr;
    logic       all_diff;
    if (!reset_n) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_deb = 4'hF; m_prev = 4'hF;
      m_mask = 4'h0; m_cap_f = 4'h0; m_cap_b = 4'h0;
      m_win.delete();
      return;
    end
    fall = m_prev & ~m_deb;
    rise = ~m_prev & m_deb;
    clr  = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
    m_cap_f = fall | (m_cap_f & ~clr);
    m_cap_b = (fall | rise) | (m_cap_b & ~clr);
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
    m_win.push_back(m_s2);
    if (m_win.size() > D) void'(m_win.pop_front());
    m_prev = m_deb;
    if (m_win.size() == D) begin
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        foreach (m_win[k]) if (m_win[k][b] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) m_deb[b] = ~m_deb[b];
      end
    end
    m_s2 = m_s1;
    m_s1 = in_port;
  endtask

  function automatic logic [31:0] model_rd(input logic [3:0] cap);
    case (address)
      2'd0:    return {28'd0, m_deb};
      2'd2:    return {28'd0, m_mask};
      2'd3:    return {28'd0, cap};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_model();
    check_eq("rd_fall", rd_f, model_rd(m_cap_f));
    check_eq("rd_both", rd_b, model_rd(m_cap_b));
    check_eq("irq_fall", {31'd0, irq_f}, {31'd0, |(m_cap_f & m_mask)});
    check_eq("irq_both", {31'd0, irq_b}, {31'd0, |(m_cap_b & m_mask)});
  endtask

  // One clock: inputs are stable from the previous falling edge; outputs are
  // checked on the next falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic bus_idle();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    cycle();
    bus_idle();
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; in_port = 4'hF;
    bus_idle();
    @(negedge clk);

    // T1: reset state
    for (int i = 0; i < 3; i++) cycle();
    check_eq("t1_data", rd_f, 32'h0000_000F);
    address = 2'd2; #1 check_eq("t1_mask", rd_f, 32'd0);
    address = 2'd3; #1 check_eq("t1_cap", rd_f, 32'd0);
    check_eq("t1_irq", {31'd0, irq_f}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    check_eq("t1_nocap", rd_b, 32'd0);

    // T2: press bit0, DATA changes exactly 2+D cycles after the pin
    address = 2'd0; in_port = 4'hE;
    for (int i = 0; i < 5; i++) cycle();
    check_eq("t2_data_early", rd_f, 32'h0000_000F);
    cycle();
    check_eq("t2_data", rd_f, 32'h0000_000E);
    address = 2'd3; #1 check_eq("t2_cap_early", rd_f, 32'd0);
    cycle();
    check_eq("t2_cap", rd_f, 32'h0000_0001);
    check_eq("t2_irq", {31'd0, irq_f}, 32'd0);

    // T3: 3-cycle glitch on bit1 is rejected
    in_port = 4'hC;
    for (int i = 0; i < 3; i++) cycle();
    in_port = 4'hE; address = 2'd0;
    for (int i = 0; i < 8; i++) cycle();
    check_eq("t3_data", rd_f, 32'h0000_000E);
    address = 2'd3; #1 check_eq("t3_cap", rd_f, 32'h0000_0001);

    // T4: enable, then clear
    bus_write(2'd2, 32'h1);
    check_eq("t4_irq_on", {31'd0, irq_f}, 32'd1);
    bus_write(2'd3, 32'h1);
    check_eq("t4_irq_off", {31'd0, irq_f}, 32'd0);
    address = 2'd3; #1 check_eq("t4_cap", rd_f, 32'd0);

    // T5: falling edge on bit2 lands in the same cycle as its clear
    in_port = 4'hA;
    for (int i = 0; i < 6; i++) cycle();
    bus_write(2'd3, 32'h4);
    address = 2'd3; #1 check_eq("t5_collision", rd_f, 32'h0000_0004);

    // T6: release in both-edge instance re-sets a cleared capture
    bus_write(2'd3, 32'hF);
    address = 2'd3; #1 check_eq("t6_cleared", rd_b, 32'd0);
    in_port = 4'hE;
    for (int i = 0; i < 7; i++) cycle();
    check_eq("t6_release_cap", rd_b, 32'h0000_0004);
    check_eq("t6_fall_nocap", rd_f, 32'd0);
    // reset pulse in the middle of debouncing bit0's release
    in_port = 4'hF;
    for (int i = 0; i < 3; i++) cycle();
    reset_n = 1'b0; cycle(); reset_n = 1'b1;
    address = 2'd0;
    for (int i = 0; i < 8; i++) cycle();
    check_eq("t6_rst_data", rd_f, 32'h0000_000F);
    address = 2'd3; #1 check_eq("t6_rst_cap", rd_b, 32'd0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) in_port[b] = ~in_port[b];
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 1) == 1);
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      reset_n    = ($urandom_range(0, 799) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
